// File: rtl/rtc_pkg.sv
// Shared widths, limits and time payload types for the hour/minute/second RTC.
package rtc_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned SEC_W    = 6;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } rtc_time_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic              pm;
  } rtc_hour12_t;

  // Midnight and noon both present as 12; pm flags the afternoon half.
  function automatic rtc_hour12_t to_12h(input logic [HOUR_W-1:0] hour24);
    rtc_hour12_t r;
    r.pm = (hour24 >= HOUR_W'(12));
    if (hour24 == '0) begin
      r.hour = HOUR_W'(12);
    end else if (hour24 > HOUR_W'(12)) begin
      r.hour = hour24 - HOUR_W'(12);
    end else begin
      r.hour = hour24;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides enabled clk cycles down to a one-per-second tick; clr restarts the count.
module rtc_prescaler #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/rtc_hms_counter.sv
// Time-of-day counter kept in 24h form with prescaler, validated load and 12h presentation.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter int unsigned PRESCALE   = 100,
  parameter int unsigned RESET_HOUR = 0,
  parameter int unsigned RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
`ifdef RTC_ALARM_EN
  input  logic       alarm_set,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_on,
  output logic       alarm_hit,
`endif
  input  logic       mode_12h,
  output logic [4:0] hour,
  output logic       pm,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_pulse,
  output logic       day_wrap,
  output logic       load_err
);

  rtc_time_t   time_q, time_d, time_inc;
  rtc_hour12_t hour12;
  logic        sec_pulse_q, sec_pulse_d;
  logic        day_wrap_q, day_wrap_d;
  logic        load_err_q, load_err_d;
  logic        tick, load_ok, at_day_end;

  assign load_ok = load
                && (load_hour <= HOUR_W'(HOUR_MAX))
                && (load_min  <= MIN_W'(MIN_MAX))
                && (load_sec  <= SEC_W'(SEC_MAX));

  rtc_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rstn(rstn),
    .en  (en),
    .clr (load_ok),
    .tick(tick)
  );

  // Ripple-carry increment of the time-of-day.
  always_comb begin
    time_inc = time_q;
    if (time_q.sec == SEC_W'(SEC_MAX)) begin
      time_inc.sec = '0;
      if (time_q.min == MIN_W'(MIN_MAX)) begin
        time_inc.min  = '0;
        time_inc.hour = (time_q.hour == HOUR_W'(HOUR_MAX)) ? '0 : time_q.hour + HOUR_W'(1);
      end else begin
        time_inc.min = time_q.min + MIN_W'(1);
      end
    end else begin
      time_inc.sec = time_q.sec + SEC_W'(1);
    end
  end

  assign at_day_end = (time_q.hour == HOUR_W'(HOUR_MAX))
                   && (time_q.min  == MIN_W'(MIN_MAX))
                   && (time_q.sec  == SEC_W'(SEC_MAX));

`ifdef RTC_ALARM_EN
  logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
  logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;
  logic              alarm_hit_q, alarm_hit_d;
  logic              alarm_ok;

  assign alarm_ok = alarm_set
                 && (alarm_hour <= HOUR_W'(HOUR_MAX))
                 && (alarm_min  <= MIN_W'(MIN_MAX));
`endif

  // A valid load overrides the tick; a rejected load lets counting proceed.
  always_comb begin
    time_d      = time_q;
    sec_pulse_d = 1'b0;
    day_wrap_d  = 1'b0;
    load_err_d  = load && !load_ok;
    if (load_ok) begin
      time_d = '{hour: load_hour, min: load_min, sec: load_sec};
    end else if (tick) begin
      time_d      = time_inc;
      sec_pulse_d = 1'b1;
      day_wrap_d  = at_day_end;
    end
`ifdef RTC_ALARM_EN
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_hit_d  = !load_ok && tick && alarm_on
                && (time_inc.hour == alarm_hour_q)
                && (time_inc.min  == alarm_min_q)
                && (time_inc.sec  == '0);
    if (alarm_ok) begin
      alarm_hour_d = alarm_hour;
      alarm_min_d  = alarm_min;
    end
    if (alarm_set && !alarm_ok) begin
      load_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      time_q      <= '{hour: HOUR_W'(RESET_HOUR), min: MIN_W'(RESET_MIN), sec: '0};
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      time_q      <= time_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
      load_err_q  <= load_err_d;
    end
  end

`ifdef RTC_ALARM_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      alarm_hit_q  <= 1'b0;
    end else begin
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hit_q  <= alarm_hit_d;
    end
  end

  assign alarm_hit = alarm_hit_q;
`endif

  assign hour12    = to_12h(time_q.hour);
  assign hour      = mode_12h ? hour12.hour : time_q.hour;
  assign pm        = hour12.pm;
  assign min       = time_q.min;
  assign sec       = time_q.sec;
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Bench for rtc_hms_counter: directed corner sequences, a mode table and random traffic vs a seconds-of-day model.
module tb_rtc_hms_counter;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rstn, en, load, mode_12h;
  logic [4:0] load_hour;
  logic [5:0] load_min, load_sec;
  logic [4:0] hour;
  logic       pm;
  logic [5:0] min, sec;
  logic       sec_pulse, day_wrap, load_err;
`ifdef RTC_ALARM_EN
  logic       alarm_set, alarm_on, alarm_hit;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference state: seconds since midnight plus prescaler phase.
  int m_tod, m_pcnt;
  bit m_sp, m_dw, m_le;
`ifdef RTC_ALARM_EN
  int m_alarm_tod;
  bit m_ah;
`endif

  always #5 clk = ~clk;

  rtc_hms_counter #(.PRESCALE(P), .RESET_HOUR(0), .RESET_MIN(0)) dut (
    .clk(clk), .rstn(rstn), .en(en), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
`ifdef RTC_ALARM_EN
    .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_on(alarm_on), .alarm_hit(alarm_hit),
`endif
    .mode_12h(mode_12h), .hour(hour), .pm(pm), .min(min), .sec(sec),
    .sec_pulse(sec_pulse), .day_wrap(day_wrap), .load_err(load_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_hour(input int h24, input bit m12);
    if (!m12) return h24;
    return (h24 % 12 == 0) ? 12 : h24 % 12;
  endfunction

  // Advance the reference by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit valid, tick;
    valid = load && (int'(load_hour) < 24) && (int'(load_min) < 60) && (int'(load_sec) < 60);
    tick  = en && (m_pcnt == P - 1);
    m_sp = 0; m_dw = 0; m_le = load && !valid;
`ifdef RTC_ALARM_EN
    m_ah = 0;
`endif
    if (!rstn) begin
      m_tod = 0; m_pcnt = 0; m_le = 0;
`ifdef RTC_ALARM_EN
      m_alarm_tod = 0;
`endif
      return;
    end
    if (valid) begin
      m_tod  = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
      m_pcnt = 0;
    end else begin
      if (en) m_pcnt = (m_pcnt + 1) % P;
      if (tick) begin
        m_tod = (m_tod + 1) % 86400;
        m_sp  = 1;
        m_dw  = (m_tod == 0);
`ifdef RTC_ALARM_EN
        m_ah  = alarm_on && (m_tod == m_alarm_tod);
`endif
      end
    end
`ifdef RTC_ALARM_EN
    if (alarm_set) begin
      if (int'(alarm_hour) < 24 && int'(alarm_min) < 60)
        m_alarm_tod = int'(alarm_hour) * 3600 + int'(alarm_min) * 60;
      else
        m_le = 1;
    end
`endif
  endtask

  task automatic compare_all();
    check("hour", int'(hour), exp_hour(m_tod / 3600, mode_12h));
    check("pm", int'(pm), int'(m_tod / 3600 >= 12));
    check("min", int'(min), (m_tod / 60) % 60);
    check("sec", int'(sec), m_tod % 60);
    check("sec_pulse", int'(sec_pulse), int'(m_sp));
    check("day_wrap", int'(day_wrap), int'(m_dw));
    check("load_err", int'(load_err), int'(m_le));
`ifdef RTC_ALARM_EN
    check("alarm_hit", int'(alarm_hit), int'(m_ah));
`endif
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1; load_hour = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    cycle();
    load = 1'b0;
  endtask

  task automatic wait_pulse(input string name, output int at);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!sec_pulse && n < 20);
    checks++;
    if (!sec_pulse) begin
      failures++;
      $display("FAIL %s: no sec_pulse within 20 cycles (got 0 expected 1)", name);
    end
    at = cyc;
  endtask

  typedef struct {
    int h24;
    bit m12;
    int exp_h;
    int exp_pm;
  } mode_vec_t;

  initial begin
    mode_vec_t vecs[10];
    int t0, t1;

    vecs[0] = '{0, 1, 12, 0};  vecs[1] = '{11, 1, 11, 0}; vecs[2] = '{12, 1, 12, 1};
    vecs[3] = '{13, 1, 1, 1};  vecs[4] = '{23, 1, 11, 1};
    vecs[5] = '{0, 0, 0, 0};   vecs[6] = '{11, 0, 11, 0}; vecs[7] = '{12, 0, 12, 1};
    vecs[8] = '{13, 0, 13, 1}; vecs[9] = '{23, 0, 23, 1};

    rstn = 1'b0; en = 1'b0; load = 1'b0; mode_12h = 1'b0;
    load_hour = '0; load_min = '0; load_sec = '0;
`ifdef RTC_ALARM_EN
    alarm_set = 1'b0; alarm_on = 1'b0; alarm_hour = '0; alarm_min = '0;
`endif
    m_tod = 0; m_pcnt = 0;
    cycle(); cycle();
    check("reset_sec", int'(sec), 0);
    rstn = 1'b1;

    // Reset: reach 12:34:56, glitch rstn between edges, then a real reset.
    en = 1'b1;
    do_load(12, 34, 55);
    wait_pulse("reach_123456", t0);
    check("pre_reset_hour", int'(hour), 12);
    check("pre_reset_sec", int'(sec), 56);
    en = 1'b0;
    rstn = 1'b0; #2;
    check("async_rst_hour", int'(hour), 12);
    check("async_rst_min", int'(min), 34);
    rstn = 1'b1;
    cycle();
    rstn = 1'b0;
    cycle();
    check("rst_hour", int'(hour), 0);
    check("rst_min", int'(min), 0);
    check("rst_sec", int'(sec), 0);
    rstn = 1'b1;
    en = 1'b1;
    t0 = cyc;
    wait_pulse("post_reset_phase", t1);
    check("post_reset_pcnt0", t1 - t0, P);

    // Pulse period and en gap.
    wait_pulse("period_a", t0);
    wait_pulse("period_b", t1);
    check("pulse_period", t1 - t0, P);
    en = 1'b0;
    cycle(); cycle(); cycle();
    en = 1'b1;
    wait_pulse("en_gap", t1);
    check("pulse_gap", t1 - t0 - P, P + 3);

    // Day wrap.
    do_load(23, 59, 58);
    wait_pulse("wrap_a", t0);
    check("wrap_a_sec", int'(sec), 59);
    check("wrap_a_dw", int'(day_wrap), 0);
    wait_pulse("wrap_b", t0);
    check("wrap_hour", int'(hour), 0);
    check("wrap_min", int'(min), 0);
    check("wrap_dw", int'(day_wrap), 1);
    cycle();
    check("wrap_dw_once", int'(day_wrap), 0);

    // Invalid load, then load colliding with a tick.
    do_load(5, 6, 7);
    do_load(24, 0, 0);
    check("bad_load_err", int'(load_err), 1);
    check("bad_load_hour", int'(hour), 5);
    check("bad_load_sec", int'(sec), 7);
    cycle();
    check("bad_load_err_once", int'(load_err), 0);
    wait_pulse("after_bad", t0);
    check("after_bad_sec", int'(sec), 8);
    cycle(); cycle(); cycle();
    do_load(9, 10, 11);
    check("collide_sec", int'(sec), 11);
    check("collide_pulse", int'(sec_pulse), 0);

    // 12h/24h mapping table.
    en = 1'b0;
    foreach (vecs[i]) begin
      mode_12h = vecs[i].m12;
      do_load(vecs[i].h24, 0, 0);
      check($sformatf("mode_hour_%0d", i), int'(hour), vecs[i].exp_h);
      check($sformatf("mode_pm_%0d", i), int'(pm), vecs[i].exp_pm);
      mode_12h = ~vecs[i].m12; #1;
      check($sformatf("mode_flip_%0d", i), int'(hour), exp_hour(vecs[i].h24, ~vecs[i].m12));
    end
    mode_12h = 1'b0;
    en = 1'b1;

`ifdef RTC_ALARM_EN
    alarm_set = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
    cycle();
    alarm_set = 1'b0; alarm_on = 1'b1;
    do_load(7, 29, 59);
    wait_pulse("alarm_on", t0);
    check("alarm_hit", int'(alarm_hit), 1);
    cycle();
    check("alarm_hit_once", int'(alarm_hit), 0);
    alarm_on = 1'b0;
    do_load(7, 29, 59);
    wait_pulse("alarm_off", t0);
    check("alarm_off_hit", int'(alarm_hit), 0);
    alarm_on = 1'b1;
    do_load(7, 30, 0);
    check("alarm_load_hit", int'(alarm_hit), 0);
    alarm_set = 1'b1; alarm_hour = 5'd25;
    cycle();
    alarm_set = 1'b0;
    check("alarm_bad_err", int'(load_err), 1);
`endif

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rstn = ($urandom_range(0, 499) != 0);
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        load_hour = 5'd23; load_min = 6'd59; load_sec = 6'($urandom_range(55, 59));
      end else begin
        load_hour = 5'($urandom_range(0, 26));
        load_min  = 6'($urandom_range(0, 62));
        load_sec  = 6'($urandom_range(0, 62));
      end
      if ($urandom_range(0, 15) == 0) mode_12h = ~mode_12h;
`ifdef RTC_ALARM_EN
      alarm_on   = ($urandom_range(0, 1) != 0);
      alarm_set  = ($urandom_range(0, 59) == 0);
      alarm_hour = load_hour;
      alarm_min  = ($urandom_range(0, 1) != 0) ? 6'(int'(load_min) + 1) : load_min;
`endif
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
